// File: rtl/frost32_mem_access_ctrl_pkg.sv
// Shared CPU data-port types, controller state encodings and the lane helper.
// Contents: DataInoutAccessType/Size, StIdle/StWait/StDone state constants,
// the default mem_ack timeout, and byte_en_f (byte lanes from size and offset).
package PkgFrost32Cpu;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] StIdle = 2'd0;
    localparam logic [STATE_W-1:0] StWait = 2'd1;
    localparam logic [STATE_W-1:0] StDone = 2'd2;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Little-endian byte lanes selected by an access of 'size' at byte offset 'off'.
    function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            Dias32:  be = 4'b1111;
            Dias16:  be = off[1] ? 4'b1100 : 4'b0011;
            Dias8:   be = 4'b0001 << off;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/frost32_mem_access_ctrl_lane_align.sv
// Combinational lane steering between the CPU and a 32-bit little-endian memory.
// Ports: size/off select the lanes; store_data is right-justified CPU data;
// load_word is the raw memory word. Outputs: byte_en_c, store_lanes_c
// (store data replicated into every lane group), load_data_c (zero-extended).
module frost32_mem_lane_align
    import PkgFrost32Cpu::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en_c,
    output logic [31:0] store_lanes_c,
    output logic [31:0] load_data_c
);

    assign byte_en_c = byte_en_f(size, off);

    // Replicating the store data means the byte enables alone pick the lane.
    always_comb begin
        store_lanes_c = '0;
        load_data_c   = '0;
        case (size)
            Dias32: begin
                store_lanes_c = store_data;
                load_data_c   = load_word;
            end
            Dias16: begin
                store_lanes_c = {2{store_data[15:0]}};
                load_data_c   = (load_word >> {off[1], 4'b0000}) & 32'h0000_FFFF;
            end
            Dias8: begin
                store_lanes_c = {4{store_data[7:0]}};
                load_data_c   = (load_word >> {off, 3'b000}) & 32'h0000_00FF;
            end
            default: begin
                store_lanes_c = '0;
                load_data_c   = '0;
            end
        endcase
    end

endmodule

// File: rtl/frost32_mem_access_ctrl.sv
// Frost32 data-memory access controller: turns a CPU load/store request into a
// held mem_req/mem_ack handshake, stalls the CPU until it completes, and flags
// bad sizes and mem_ack timeouts with a one-cycle access_err in StDone.
// CPU side : cpu_req_mem_access, cpu_addr, cpu_wdata, cpu_access_type,
//            cpu_access_size in; cpu_rdata, cpu_stall (combinational), access_err out.
// Mem side : mem_req, mem_we, mem_word_addr, mem_byte_en, mem_wdata out;
//            mem_ack, mem_rdata in.
// Build option: FROST32_MEM_ALIGN_CHECK_EN makes misaligned 16/32-bit accesses
// errors; without it the offending low address bits are forced to zero.
module frost32_mem_access_ctrl
    import PkgFrost32Cpu::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_mem_access,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_access_type,
    input  logic [1:0]  cpu_access_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        access_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_word_addr,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // The counter only has to reach TIMEOUT_CYCLES-1 (the last waiting cycle).
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [29:0]        mem_word_addr_q, mem_word_addr_d;
    logic [3:0]         mem_byte_en_q, mem_byte_en_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               access_err_q, access_err_d;

    logic [1:0]  req_off_c;
    logic        req_bad_c;
    logic [1:0]  lane_size_c;
    logic [1:0]  lane_off_c;
    logic [3:0]  lane_byte_en_c;
    logic [31:0] lane_wdata_c;
    logic [31:0] lane_rdata_c;

    // Offset actually used for lane selection: sub-size bits cleared for 16/32-bit.
    always_comb begin
        req_off_c = cpu_addr[1:0];
        if (cpu_access_size == Dias32) begin
            req_off_c = 2'b00;
        end else if (cpu_access_size == Dias16) begin
            req_off_c = {cpu_addr[1], 1'b0};
        end
    end

`ifdef FROST32_MEM_ALIGN_CHECK_EN
    logic misalign_c;

    always_comb begin
        misalign_c = 1'b0;
        if (cpu_access_size == Dias32) begin
            misalign_c = |cpu_addr[1:0];
        end else if (cpu_access_size == Dias16) begin
            misalign_c = cpu_addr[0];
        end
    end

    assign req_bad_c = (cpu_access_size == DiasBad) || misalign_c;
`else
    assign req_bad_c = (cpu_access_size == DiasBad);
`endif

    // One lane aligner serves both directions: live CPU fields while accepting,
    // latched fields while waiting for the load word.
    assign lane_size_c = (state_q == StIdle) ? cpu_access_size : size_q;
    assign lane_off_c  = (state_q == StIdle) ? req_off_c       : off_q;

    frost32_mem_lane_align u_lane_align (
        .size          (lane_size_c),
        .off           (lane_off_c),
        .store_data    (cpu_wdata),
        .load_word     (mem_rdata),
        .byte_en_c     (lane_byte_en_c),
        .store_lanes_c (lane_wdata_c),
        .load_data_c   (lane_rdata_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        size_d          = size_q;
        off_d           = off_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_word_addr_d = mem_word_addr_q;
        mem_byte_en_d   = mem_byte_en_q;
        mem_wdata_d     = mem_wdata_q;
        cpu_rdata_d     = cpu_rdata_q;
        access_err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (cpu_req_mem_access) begin
                    size_d = cpu_access_size;
                    off_d  = req_off_c;
                    if (req_bad_c) begin
                        state_d      = StDone;
                        access_err_d = 1'b1;
                        cpu_rdata_d  = '0;
                    end else begin
                        state_d         = StWait;
                        cnt_d           = '0;
                        mem_req_d       = 1'b1;
                        mem_we_d        = (cpu_access_type == DiatWrite);
                        mem_word_addr_d = cpu_addr[31:2];
                        mem_byte_en_d   = lane_byte_en_c;
                        mem_wdata_d     = lane_wdata_c;
                    end
                end
            end
            StWait: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    state_d     = StDone;
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = lane_rdata_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = StDone;
                    mem_req_d    = 1'b0;
                    access_err_d = 1'b1;
                    cpu_rdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            size_q          <= '0;
            off_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_word_addr_q <= '0;
            mem_byte_en_q   <= '0;
            mem_wdata_q     <= '0;
            cpu_rdata_q     <= '0;
            access_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            size_q          <= size_d;
            off_q           <= off_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_word_addr_q <= mem_word_addr_d;
            mem_byte_en_q   <= mem_byte_en_d;
            mem_wdata_q     <= mem_wdata_d;
            cpu_rdata_q     <= cpu_rdata_d;
            access_err_q    <= access_err_d;
        end
    end

    // Stall is combinational so the CPU holds in the same cycle it asks.
    assign cpu_stall = !rst && ((state_q == StWait) ||
                                ((state_q == StIdle) && cpu_req_mem_access));

    assign cpu_rdata     = cpu_rdata_q;
    assign access_err    = access_err_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_word_addr = mem_word_addr_q;
    assign mem_byte_en   = mem_byte_en_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: doc/frost32_mem_access_ctrl.md
FROST32_MEM_ACCESS_CTRL -- requirements
Module: frost32_mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack before error.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req_mem_access  in  1  CPU requests a data access.
REQ-005 SHALL have port cpu_addr  in  32  byte address.
REQ-006 SHALL have port cpu_wdata  in  32  store data, right-justified.
REQ-007 SHALL have port cpu_access_type  in  1  DataInoutAccessType (DiatRead/DiatWrite).
REQ-008 SHALL have port cpu_access_size  in  2  DataInoutAccessSize (Dias32/Dias16/Dias8/DiasBad).
REQ-009 SHALL have port cpu_rdata  out  32  load data to CPU (PortIn_Frost32Cpu.data).
REQ-010 SHALL have port cpu_stall  out  1  CPU stall (PortIn_Frost32Cpu.stall).
REQ-011 SHALL have port access_err  out  1  one-cycle pulse: bad size, misaligned, or timeout.
REQ-012 SHALL have port mem_req  out  1  memory request, held until acknowledged.
REQ-013 SHALL have port mem_we  out  1  write enable.
REQ-014 SHALL have port mem_word_addr  out  30  cpu_addr[31:2].
REQ-015 SHALL have port mem_byte_en  out  4  byte lanes, bit n = bits 8n+7:8n.
REQ-016 SHALL have port mem_wdata  out  32  lane-aligned store data.
REQ-017 SHALL have port mem_ack  in  1  memory completes the request this cycle.
REQ-018 SHALL have port mem_rdata  in  32  read word, valid with mem_ack.

Function
REQ-019 SHALL implement states StIdle, StWait, StDone.
REQ-020 StIdle: cpu_req_mem_access sampled; if high, latch addr/wdata/type/size and go StWait (or StDone with error per REQ-026/027).
REQ-021 cpu_stall SHALL be combinational: 1 in StWait, 1 in StIdle while cpu_req_mem_access=1, else 0.
REQ-022 StWait: mem_req=1 with latched fields stable; on mem_ack capture data, go StDone; minimum latency request-to-release 2 cycles.
REQ-023 StDone: cpu_rdata valid, stall 0, cpu_req_mem_access ignored; next state StIdle unconditionally.
REQ-024 Lanes little-endian: Dias8 byte_en = 1<<addr[1:0]; Dias16 byte_en = addr[1]?4'b1100:4'b0011; Dias32 4'b1111.
REQ-025 Stores replicate data into selected lanes; loads extract selected lanes, zero-extended to 32 bits.
REQ-026 DiasBad SHALL skip memory, pulse access_err in StDone, cpu_rdata=0.
REQ-027 Timeout counter cleared on StWait entry; at TIMEOUT_CYCLES without mem_ack, drop mem_req, go StDone, pulse access_err, cpu_rdata=0.
REQ-028 mem_ack outside StWait SHALL be ignored; mem_ack on the timeout cycle completes normally (ack wins).
REQ-029 cpu_rdata SHALL hold last value outside StDone.

Reset
REQ-030 On rst: state StIdle, mem_req=0, mem_we=0, mem_byte_en=0, mem_word_addr=0, mem_wdata=0, cpu_rdata=0, access_err=0, timeout counter 0.
REQ-031 rst asserted mid-access SHALL abort immediately; no completion or error reported afterwards.

Configuration
REQ-032 Macro FROST32_MEM_ALIGN_CHECK_EN: defined -> Dias32 with addr[1:0]!=0 or Dias16 with addr[0]=1 treated as REQ-026 error; undefined -> offending low address bits forced to 0 and access proceeds.

Structure
REQ-033 State enum, TIMEOUT default constant, and byte-enable helper function SHALL live in PkgFrost32Cpu; reuse existing DataInoutAccessType/Size.
REQ-034 One sub-module natural: frost32_mem_lane_align (combinational byte-enable, store replicate, load extract).

Verification
REQ-035 Word read addr 0x100, mem_ack after 3 cycles, rdata 0xDEADBEEF -> cpu_rdata 0xDEADBEEF in StDone, stall high 4 cycles.
REQ-036 Dias8 write addr 0x103 data 0xA5 -> mem_byte_en 4'b1000, mem_wdata 0xA5A5A5A5, mem_we 1.
REQ-037 Dias16 read addr 0x202, mem_rdata 0x1234ABCD -> cpu_rdata 0x00001234.
REQ-038 TIMEOUT_CYCLES=4, no mem_ack -> mem_req drops after 4 cycles, access_err 1-cycle pulse, cpu_rdata 0.
REQ-039 Dias32 at 0x101: macro defined -> access_err, no mem_req; undefined -> mem_word_addr 0x40, access proceeds.
REQ-040 rst asserted in StWait -> all outputs at reset values same cycle, no access_err.
